// File: rtl/sram_word_responder.sv
// LSU data-memory responder: one 32-bit request per access,
// split into two 16-bit halves on an IS61WV25616 async SRAM.
module sram_word_responder #(
   parameter int WAIT_CYCLES = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [17:0] i_ADDR,
   input  logic [31:0] i_WDATA,
   input  logic [3:0]  i_BMASK,
   input  logic        i_WREN,
   input  logic        i_RDEN,
   output logic [31:0] o_RDATA,
   output logic        o_ACK,
   output logic [17:0] SRAM_ADDR,
   inout  wire  [15:0] SRAM_DQ,
   output logic        SRAM_CE_N,
   output logic        SRAM_WE_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_LB_N,
   output logic        SRAM_UB_N
);

   localparam logic [3:0] LP_W = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LO,
      S_HI,
      S_DONE
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt_nxt;

   logic        r_wr;
   logic [15:0] r_word;
   logic [31:0] r_wdata;
   logic [3:0]  r_mask;
   logic [31:0] r_rdata;
   logic        r_ack;
   logic [17:0] r_addr;
   logic        r_ce_n;
   logic        r_we_n;
   logic        r_oe_n;
   logic        r_lb_n;
   logic        r_ub_n;

   logic        w_acc;
   logic        w_wr;
   logic [3:0]  w_mask;
   logic [15:0] w_word;
   logic        w_last;
   logic        w_busy;
   logic        w_half;
   logic [1:0]  w_lane;
   logic [17:0] w_addr_nxt;
   logic        w_ce_nxt;
   logic        w_we_nxt;
   logic        w_oe_nxt;
   logic        w_lb_nxt;
   logic        w_ub_nxt;
   logic        w_ack_nxt;
   logic        w_dq_oe;
   logic [15:0] w_dq_out;
   logic        w_unused_addr;

   assign w_unused_addr = &{1'b0, i_ADDR[1:0]};

   // At acceptance the request fields are not latched yet,
   // so the first-cycle outputs are decoded from the inputs.
   assign w_acc  = (r_state == S_IDLE) && (i_WREN || i_RDEN);
   assign w_wr   = w_acc ? i_WREN        : r_wr;
   assign w_mask = w_acc ? i_BMASK       : r_mask;
   assign w_word = w_acc ? i_ADDR[17:2]  : r_word;
   assign w_last = (r_cnt == LP_W);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
         S_IDLE: begin
            if (w_acc) begin
               w_state_nxt = S_LO;
               w_cnt_nxt   = 4'd0;
            end
         end
         S_LO: begin
            if (w_last) begin
               w_state_nxt = S_HI;
               w_cnt_nxt   = 4'd0;
            end else begin
               w_cnt_nxt = r_cnt + 4'd1;
            end
         end
         S_HI: begin
            if (w_last) begin
               w_state_nxt = S_DONE;
               w_cnt_nxt   = 4'd0;
            end else begin
               w_cnt_nxt = r_cnt + 4'd1;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 4'd0;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 4'd0;
         end
      endcase
   end

   always_comb begin
      w_busy     = (w_state_nxt == S_LO) || (w_state_nxt == S_HI);
      w_half     = (w_state_nxt == S_HI);
      w_lane     = w_half ? w_mask[3:2] : w_mask[1:0];
      w_addr_nxt = r_addr;
      w_ce_nxt   = 1'b1;
      w_we_nxt   = 1'b1;
      w_oe_nxt   = 1'b1;
      w_lb_nxt   = 1'b1;
      w_ub_nxt   = 1'b1;
      w_ack_nxt  = (w_state_nxt == S_DONE);
      if (w_busy) begin
         w_addr_nxt = {1'b0, w_word, w_half};
         w_ce_nxt   = 1'b0;
         if (w_wr) begin
            w_lb_nxt = ~w_lane[0];
            w_ub_nxt = ~w_lane[1];
            // last cycle of each phase is address/data hold
            w_we_nxt = ~((|w_lane) && (w_cnt_nxt < LP_W));
         end else begin
            w_oe_nxt = 1'b0;
            w_lb_nxt = 1'b0;
            w_ub_nxt = 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_wr    <= 1'b0;
         r_word  <= 16'd0;
         r_wdata <= 32'd0;
         r_mask  <= 4'd0;
         r_rdata <= 32'd0;
         r_ack   <= 1'b0;
         r_addr  <= 18'd0;
         r_ce_n  <= 1'b1;
         r_we_n  <= 1'b1;
         r_oe_n  <= 1'b1;
         r_lb_n  <= 1'b1;
         r_ub_n  <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ack   <= w_ack_nxt;
         r_addr  <= w_addr_nxt;
         r_ce_n  <= w_ce_nxt;
         r_we_n  <= w_we_nxt;
         r_oe_n  <= w_oe_nxt;
         r_lb_n  <= w_lb_nxt;
         r_ub_n  <= w_ub_nxt;
         if (w_acc) begin
            r_wr    <= i_WREN;
            r_word  <= i_ADDR[17:2];
            r_wdata <= i_WDATA;
            r_mask  <= i_BMASK;
         end
         if (!r_wr && w_last) begin
            if (r_state == S_LO)
               r_rdata[15:0] <= SRAM_DQ;
            if (r_state == S_HI)
               r_rdata[31:16] <= SRAM_DQ;
         end
      end
   end

   assign w_dq_oe  = r_wr &&
                     ((r_state == S_LO) || (r_state == S_HI));
   assign w_dq_out = (r_state == S_HI) ? r_wdata[31:16]
                                       : r_wdata[15:0];
   assign SRAM_DQ  = w_dq_oe ? w_dq_out : 16'hzzzz;

   assign o_RDATA   = r_rdata;
   assign o_ACK     = r_ack;
   assign SRAM_ADDR = r_addr;
   assign SRAM_CE_N = r_ce_n;
   assign SRAM_WE_N = r_we_n;
   assign SRAM_OE_N = r_oe_n;
   assign SRAM_LB_N = r_lb_n;
   assign SRAM_UB_N = r_ub_n;

endmodule

// File: tb/tb_sram_word_responder.sv
// Directed bench for sram_word_responder: W=1 and W=3 instances,
// each on a small behavioural SRAM; idle bus reads back as FFFF.
module tb_sram_word_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [17:0] a1, a3;
   logic [31:0] wd1, wd3;
   logic [3:0]  bm1, bm3;
   logic        wr1, rd1, wr3, rd3;
   logic [31:0] rdat1, rdat3;
   logic        ack1, ack3;
   logic [17:0] sa1, sa3;
   tri1  [15:0] dq1, dq3;
   logic        ce1, we1, oe1, lb1, ub1;
   logic        ce3, we3, oe3, lb3, ub3;

   int errors = 0;
   int checks = 0;

   logic [15:0] mem1 [0:4095];
   logic [15:0] mem3 [0:4095];

   sram_word_responder #(.WAIT_CYCLES(1)) u_w1 (
      .i_clk(clk), .i_rst(rst),
      .i_ADDR(a1), .i_WDATA(wd1), .i_BMASK(bm1),
      .i_WREN(wr1), .i_RDEN(rd1),
      .o_RDATA(rdat1), .o_ACK(ack1),
      .SRAM_ADDR(sa1), .SRAM_DQ(dq1),
      .SRAM_CE_N(ce1), .SRAM_WE_N(we1), .SRAM_OE_N(oe1),
      .SRAM_LB_N(lb1), .SRAM_UB_N(ub1)
   );

   sram_word_responder #(.WAIT_CYCLES(3)) u_w3 (
      .i_clk(clk), .i_rst(rst),
      .i_ADDR(a3), .i_WDATA(wd3), .i_BMASK(bm3),
      .i_WREN(wr3), .i_RDEN(rd3),
      .o_RDATA(rdat3), .o_ACK(ack3),
      .SRAM_ADDR(sa3), .SRAM_DQ(dq3),
      .SRAM_CE_N(ce3), .SRAM_WE_N(we3), .SRAM_OE_N(oe3),
      .SRAM_LB_N(lb3), .SRAM_UB_N(ub3)
   );

   // SRAM models: write lanes while CE/WE low, drive on OE
   always @(posedge clk) begin
      if (!ce1 && !we1) begin
         if (!lb1) mem1[sa1[11:0]][7:0]  <= dq1[7:0];
         if (!ub1) mem1[sa1[11:0]][15:8] <= dq1[15:8];
      end
      if (!ce3 && !we3) begin
         if (!lb3) mem3[sa3[11:0]][7:0]  <= dq3[7:0];
         if (!ub3) mem3[sa3[11:0]][15:8] <= dq3[15:8];
      end
   end

   assign dq1 = (!ce1 && !oe1 && we1) ? mem1[sa1[11:0]]
                                      : 16'hzzzz;
   assign dq3 = (!ce3 && !oe3 && we3) ? mem3[sa3[11:0]]
                                      : 16'hzzzz;

   task automatic start1(input logic [17:0] a,
                         input logic [31:0] d,
                         input logic [3:0]  m,
                         input logic        w,
                         input logic        r);
      @(negedge clk);
      a1 = a; wd1 = d; bm1 = m; wr1 = w; rd1 = r;
      @(posedge clk);
      #1;
      wr1 = 1'b0; rd1 = 1'b0;
      a1 = 18'h3FFFF; wd1 = 32'h0; bm1 = 4'h0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      wr1 = 1'b1; rd1 = 1'b0; a1 = 18'h2000;
      wd1 = 32'h0; bm1 = 4'hF;
      wr3 = 1'b1; rd3 = 1'b0; a3 = 18'h0100;
      wd3 = 32'h0; bm3 = 4'hF;
      repeat (3) @(negedge clk);
      checks++;
      if ({ce1, we1, oe1, lb1, ub1} !== 5'h1F ||
          {ce3, we3, oe3, lb3, ub3} !== 5'h1F) begin
         errors++;
         $display("FAIL rst_ctrl got=%b/%b want=11111",
                  {ce1, we1, oe1, lb1, ub1},
                  {ce3, we3, oe3, lb3, ub3});
      end
      checks++;
      if (dq1 !== 16'hFFFF || dq3 !== 16'hFFFF) begin
         errors++;
         $display("FAIL rst_dq got=%h/%h want=ffff(released)",
                  dq1, dq3);
      end
      checks++;
      if (ack1 !== 1'b0 || rdat1 !== 32'h0 || sa1 !== 18'h0 ||
          ack3 !== 1'b0 || rdat3 !== 32'h0 || sa3 !== 18'h0) begin
         errors++;
         $display("FAIL rst_regs ack=%b/%b rd=%h/%h sa=%h/%h want 0",
                  ack1, ack3, rdat1, rdat3, sa1, sa3);
      end
      wr1 = 1'b0; wr3 = 1'b0;
      rst = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         checks++;
         if ({ce1, we1, oe1, lb1, ub1, ack1} !== 6'b111110 ||
             dq1 !== 16'hFFFF || rdat1 !== 32'h0) begin
            errors++;
            $display("FAIL idle k=%0d ctl=%b dq=%h rd=%h want 111110 ffff 0",
                     k, {ce1, we1, oe1, lb1, ub1, ack1}, dq1, rdat1);
         end
      end
   endtask

   task automatic test_full_write();
      logic [17:0] esa;
      logic [15:0] edq;
      logic [4:0]  ectl;
      start1(18'h2000, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         esa = (k <= 2) ? 18'h01000 : 18'h01001;
         edq = (k <= 2) ? 16'hBEEF
             : (k <= 4) ? 16'hDEAD : 16'hFFFF;
         if (k == 1 || k == 3)  ectl = 5'b00100;
         else if (k <= 4)       ectl = 5'b01100;
         else                   ectl = 5'b11111;
         checks++;
         if ({ce1, we1, oe1, lb1, ub1} !== ectl || sa1 !== esa ||
             dq1 !== edq || ack1 !== (k == 5)) begin
            errors++;
            $display("FAIL wr_full k=%0d ctl=%b/%b sa=%h/%h dq=%h/%h ack=%b/%b",
                     k, {ce1, we1, oe1, lb1, ub1}, ectl, sa1, esa,
                     dq1, edq, ack1, (k == 5));
         end
      end
      checks++;
      if (mem1[12'h000] !== 16'hBEEF || mem1[12'h001] !== 16'hDEAD) begin
         errors++;
         $display("FAIL wr_mem got=%h_%h want=dead_beef",
                  mem1[12'h001], mem1[12'h000]);
      end
   endtask

   task automatic test_read(input logic [31:0] exp);
      logic [4:0] ectl;
      start1(18'h2000, 32'h0, 4'h0, 1'b0, 1'b1);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         ectl = (k <= 4) ? 5'b01000 : 5'b11111;
         checks++;
         if ({ce1, we1, oe1, lb1, ub1} !== ectl ||
             ack1 !== (k == 5)) begin
            errors++;
            $display("FAIL rd_ctl k=%0d ctl=%b/%b ack=%b/%b",
                     k, {ce1, we1, oe1, lb1, ub1}, ectl,
                     ack1, (k == 5));
         end
         if (k >= 5) begin
            checks++;
            if (rdat1 !== exp) begin
               errors++;
               $display("FAIL rd_data k=%0d got=%h want=%h",
                        k, rdat1, exp);
            end
         end
      end
   endtask

   task automatic test_byte_write();
      logic [4:0] ectl;
      start1(18'h2000, 32'h000000AA, 4'h1, 1'b1, 1'b0);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 1)      ectl = 5'b00101;
         else if (k == 2) ectl = 5'b01101;
         else if (k <= 4) ectl = 5'b01111;
         else             ectl = 5'b11111;
         checks++;
         if ({ce1, we1, oe1, lb1, ub1} !== ectl ||
             ack1 !== (k == 5)) begin
            errors++;
            $display("FAIL bw_ctl k=%0d ctl=%b/%b ack=%b/%b",
                     k, {ce1, we1, oe1, lb1, ub1}, ectl,
                     ack1, (k == 5));
         end
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      a1 = 18'h0040; wd1 = 32'h12345678; bm1 = 4'hF;
      wr1 = 1'b1; rd1 = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         checks++;
         if (ack1 !== (k == 5 || k == 11) || oe1 !== 1'b1) begin
            errors++;
            $display("FAIL b2b k=%0d ack=%b/%b oe=%b/1",
                     k, ack1, (k == 5 || k == 11), oe1);
         end
         if (k == 7) begin
            checks++;
            if (sa1 !== 18'h00020) begin
               errors++;
               $display("FAIL b2b_addr got=%h want=00020", sa1);
            end
         end
      end
      wr1 = 1'b0; rd1 = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (mem1[12'h020] !== 16'h5678 || mem1[12'h021] !== 16'h1234 ||
          rdat1 !== 32'hDEADBEAA) begin
         errors++;
         $display("FAIL b2b_mem got=%h_%h rd=%h want=1234_5678 deadbeaa",
                  mem1[12'h021], mem1[12'h020], rdat1);
      end
   endtask

   task automatic test_reset_mid_write();
      @(negedge clk);
      a3 = 18'h0100; wd3 = 32'hCAFEF00D; bm3 = 4'hF; wr3 = 1'b1;
      @(posedge clk);
      #1;
      wr3 = 1'b0; wd3 = 32'h0;
      @(negedge clk);
      checks++;
      if ({ce3, we3} !== 2'b00 || dq3 !== 16'hF00D) begin
         errors++;
         $display("FAIL w3_lo ce_we=%b/00 dq=%h/f00d", {ce3, we3}, dq3);
      end
      @(negedge clk);
      #1 rst = 1'b0;
      #1;
      checks++;
      if ({ce3, we3, oe3} !== 3'b111 || dq3 !== 16'hFFFF ||
          sa3 !== 18'h0) begin
         errors++;
         $display("FAIL w3_abort ctl=%b/111 dq=%h/ffff sa=%h/0",
                  {ce3, we3, oe3}, dq3, sa3);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         checks++;
         if (ack3 !== 1'b0 || ce3 !== 1'b1 || rdat3 !== 32'h0) begin
            errors++;
            $display("FAIL w3_noack k=%0d ack=%b/0 ce=%b/1 rd=%h/0",
                     k, ack3, ce3, rdat3);
         end
      end
      @(negedge clk);
      a3 = 18'h0100; rd3 = 1'b1;
      @(posedge clk);
      #1 rd3 = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         checks++;
         if (ack3 !== (k == 9) || oe3 !== !(k <= 8)) begin
            errors++;
            $display("FAIL w3_rd k=%0d ack=%b/%b oe=%b/%b",
                     k, ack3, (k == 9), oe3, !(k <= 8));
         end
         if (k == 9) begin
            checks++;
            if (rdat3 !== 32'h0000F00D) begin
               errors++;
               $display("FAIL w3_rdata got=%h want=0000f00d", rdat3);
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) begin
         mem1[i] <= 16'h0;
         mem3[i] <= 16'h0;
      end
      test_reset();
      test_full_write();
      test_read(32'hDEADBEEF);
      test_byte_write();
      test_read(32'hDEADBEAA);
      test_back_to_back();
      test_reset_mid_write();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
